// File: rtl/mod_reduce_pkg.sv
// Shared types and sizing helpers for the bit-serial modular reducer.
package mod_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    FIX,
    DONE
  } state_t;

  localparam int unsigned default_width = 128;
  localparam int unsigned cnt_w = $clog2(2 * default_width);

  // Counter width for an arbitrary operand width (2*w product bits to walk).
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/mod_reduce_serial_if.sv
// Enable/done handshake bundle shared with the upstream multiplier adapter.
interface mod_reduce_serial_if #(
  parameter int width = 128
);
  logic [2*width-1:0] ab;
  logic [width-1:0]   modulus;
  logic               enable;
  logic [width-1:0]   result;
  logic               done;
  logic               busy;
  logic               mod_err;

  modport master (
    output ab, modulus, enable,
    input  result, done, busy, mod_err
  );

  modport slave (
    input  ab, modulus, enable,
    output result, done, busy, mod_err
  );
endinterface

// File: rtl/mod_reduce_step.sv
// One restoring-reduction step: shift a product bit into R, subtract p if it fits.
module mod_reduce_step #(
  parameter int width = 128
) (
  input  logic [width-1:0] r,
  input  logic [width-1:0] p,
  input  logic             in_bit,
  output logic [width-1:0] r_next
);
  logic [width:0] t;
  logic [width:0] p_ext;

  // With R < p on entry, t < 2p always fits in width+1 bits.
  assign t      = {r, in_bit};
  assign p_ext  = {1'b0, p};
  assign r_next = (t >= p_ext) ? width'(t - p_ext) : t[width-1:0];
endmodule

// File: rtl/mod_reduce_serial.sv
// Bit-serial reduction of a signed 2*width product modulo p, MSB first,
// followed by a sign-correction step that yields the canonical residue.
module mod_reduce_serial
  import mod_reduce_pkg::*;
#(
  parameter int width = 128
) (
  input logic               clk,
  input logic               reset,
  mod_reduce_serial_if.slave bus
);
  localparam int unsigned cw = cnt_width(width);

  state_t             state_reg;
  logic [width-1:0]   r_reg;
  logic [width-1:0]   p_reg;
  logic [2*width-1:0] mag_reg;
  logic               neg_reg;
  logic [cw-1:0]      cnt_reg;
  logic [width-1:0]   result_reg;
  logic               done_reg;
  logic               busy_reg;
  logic               err_reg;
  logic [width-1:0]   r_next;

  mod_reduce_step #(.width(width)) u_step (
    .r      (r_reg),
    .p      (p_reg),
    .in_bit (mag_reg[cnt_reg]),
    .r_next (r_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      r_reg      <= '0;
      p_reg      <= '0;
      mag_reg    <= '0;
      neg_reg    <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          err_reg  <= 1'b0;
          if (bus.enable) begin
            // Magnitude of the most negative product still fits as unsigned.
            neg_reg   <= bus.ab[2*width-1];
            mag_reg   <= bus.ab[2*width-1] ? -bus.ab : bus.ab;
            p_reg     <= bus.modulus;
            r_reg     <= '0;
            cnt_reg   <= cw'(2 * width - 1);
            busy_reg  <= 1'b1;
            state_reg <= REDUCE;
          end
        end
        REDUCE: begin
          r_reg <= r_next;
          if (cnt_reg == '0) begin
            state_reg <= FIX;
          end else begin
            cnt_reg <= cnt_reg - cw'(1);
          end
        end
        FIX: begin
          if (p_reg == '0) begin
            result_reg <= '0;
            err_reg    <= 1'b1;
          end else if (neg_reg && (r_reg != '0)) begin
            result_reg <= p_reg - r_reg;
          end else begin
            result_reg <= r_reg;
          end
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          err_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.result  = result_reg;
  assign bus.done    = done_reg;
  assign bus.busy    = busy_reg;
  assign bus.mod_err = err_reg;
endmodule
